// File: rtl/instruction_fetch.sv
// IF stage plus IF/ID pipeline register: PC generation, synchronous imem addressing,
// stall hold and delay-slot-preserving branch/jump redirects into decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   stall,
  input  logic                   jump_branch,
  input  logic                   jump_target,
  input  logic                   jump_reg,
  input  logic [31:0]            jr_pc,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            pc_id,
  output logic [31:0]            instr_id,
  output logic                   instr_valid
);

  logic [31:0] pcIf_q, pcIf_d;
  logic        ifValid_q;
  logic [31:0] pcId_q, instrId_q;
  logic        instrValid_q;
  logic [31:0] pcIdPlus4;
  logic [31:0] branchOffset;
  logic        unused_pcBits;

  assign pcIdPlus4    = pcId_q + 32'd4;
  assign branchOffset = {{14{instrId_q[15]}}, instrId_q[15:0], 2'b00};

  // The BRAM latches imem_addr on the same edge that pcIf_q takes pcIf_d, so the
  // word on imem_rdata always belongs to pcIf_q; holding pcIf_q re-reads that word.
  always_comb begin
    pcIf_d = pcIf_q;
    if (en) begin
      if (!ifValid_q || stall) begin
        pcIf_d = pcIf_q;
      end else if (instrValid_q && jump_reg) begin
        pcIf_d = {jr_pc[31:2], 2'b00};
      end else if (instrValid_q && jump_target) begin
        pcIf_d = {pcIdPlus4[31:28], instrId_q[25:0], 2'b00};
      end else if (instrValid_q && jump_branch) begin
        pcIf_d = pcIdPlus4 + branchOffset;
      end else begin
        pcIf_d = pcIf_q + 32'd4;
      end
    end
  end

  assign imem_addr     = pcIf_d[IMEM_ADDR_W+1:2];
  assign unused_pcBits = ^{pcIf_d[31:IMEM_ADDR_W+2], pcIf_d[1:0], jr_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcIf_q       <= RESET_PC;
      ifValid_q    <= 1'b0;
      pcId_q       <= 32'h0;
      instrId_q    <= 32'h0;
      instrValid_q <= 1'b0;
    end else if (en) begin
      pcIf_q    <= pcIf_d;
      ifValid_q <= 1'b1;
      // The word currently in IF (the delay slot on a redirect) advances unless decode stalls.
      if (!stall) begin
        pcId_q       <= pcIf_q;
        instrId_q    <= ifValid_q ? imem_rdata : 32'h0;
        instrValid_q <= ifValid_q;
      end
    end
  end

  assign pc_id       = pcId_q;
  assign instr_id    = instrId_q;
  assign instr_valid = instrValid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset bubble, branch/J/JR redirects with delay slots,
// stall priority, run enable, PC wrap and mid-stream reset against a behavioural BRAM.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        stall;
  logic        jumpBranch;
  logic        jumpTarget;
  logic        jumpReg;
  logic [31:0] jrPc;
  logic [9:0]  imemAddr;
  logic [31:0] imemRdata;
  logic [31:0] pcId;
  logic [31:0] instrId;
  logic        instrValid;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0100),
    .IMEM_ADDR_W(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .stall      (stall),
    .jump_branch(jumpBranch),
    .jump_target(jumpTarget),
    .jump_reg   (jumpReg),
    .jr_pc      (jrPc),
    .imem_addr  (imemAddr),
    .imem_rdata (imemRdata),
    .pc_id      (pcId),
    .instr_id   (instrId),
    .instr_valid(instrValid)
  );

  always #5 clk = ~clk;

  // One-cycle-latency instruction BRAM
  always @(posedge clk) imemRdata <= mem[imemAddr];

  function automatic logic [31:0] wordAt(input logic [31:0] pc);
    return mem[pc[11:2]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({imemAddr, instrValid, instrId, pcId} !== {10'h040, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got addr=%h v=%b ins=%h pc=%h want addr=040 v=0 ins=0 pc=0",
               imemAddr, instrValid, instrId, pcId);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_bubble: got v=%b want v=0", instrValid);
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] expPc;
      expPc = 32'h100 + 32'(4 * i);
      tick();
      checks++;
      if ({instrValid, pcId, instrId} !== {1'b1, expPc, wordAt(expPc)}) begin
        errors++;
        $display("[TB] FAIL reset_stream[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 i, instrValid, pcId, instrId, expPc, wordAt(expPc));
      end
    end
  endtask

  // Each step drives {jumpReg, jumpTarget, jumpBranch} plus jrPc, then checks the next ID entry.
  task automatic run_steps(input string name, input int n, input logic [2:0] ctl [8],
                           input logic [31:0] jr [8], input logic [31:0] expPc [8]);
    for (int i = 0; i < n; i++) begin
      {jumpReg, jumpTarget, jumpBranch} = ctl[i];
      jrPc = jr[i];
      tick();
      {jumpReg, jumpTarget, jumpBranch} = 3'b000;
      checks++;
      if ({instrValid, pcId, instrId} !== {1'b1, expPc[i], wordAt(expPc[i])}) begin
        errors++;
        $display("[TB] FAIL %s[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 name, i, instrValid, pcId, instrId, expPc[i], wordAt(expPc[i]));
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  ctl [8] = '{3'b100, 3'b000, 3'b001, 3'b000, 0, 0, 0, 0};
    logic [31:0] jr  [8] = '{32'h200, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] ex  [8] = '{32'h10C, 32'h200, 32'h204, 32'h214, 0, 0, 0, 0};
    run_steps("branch", 4, ctl, jr, ex);
  endtask

  task automatic test_jump();
    logic [2:0]  ctl [8] = '{3'b100, 3'b000, 3'b010, 3'b000, 0, 0, 0, 0};
    logic [31:0] jr  [8] = '{32'h1000_0040, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] ex  [8] = '{32'h218, 32'h1000_0040, 32'h1000_0044, 32'h1000_0040, 0, 0, 0, 0};
    run_steps("jump", 4, ctl, jr, ex);
  endtask

  task automatic test_jr();
    logic [2:0]  ctl [8] = '{3'b100, 3'b000, 0, 0, 0, 0, 0, 0};
    logic [31:0] jr  [8] = '{32'h0000_0303, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] ex  [8] = '{32'h1000_0044, 32'h300, 0, 0, 0, 0, 0, 0};
    run_steps("jr", 2, ctl, jr, ex);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    jumpBranch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({instrValid, pcId, instrId, imemAddr} !== {1'b1, 32'h300, 32'h1000_0004, 10'h0C1}) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b pc=%h ins=%h addr=%h want v=1 pc=300 ins=10000004 addr=0c1",
                 i, instrValid, pcId, instrId, imemAddr);
      end
    end
    stall = 1'b0;
    tick();
    jumpBranch = 1'b0;
    checks++;
    if ({instrValid, pcId, instrId} !== {1'b1, 32'h304, wordAt(32'h304)}) begin
      errors++;
      $display("[TB] FAIL stall_slot: got v=%b pc=%h ins=%h want v=1 pc=304", instrValid, pcId, instrId);
    end
    tick();
    checks++;
    if ({instrValid, pcId, instrId} !== {1'b1, 32'h314, wordAt(32'h314)}) begin
      errors++;
      $display("[TB] FAIL stall_target: got v=%b pc=%h ins=%h want v=1 pc=314", instrValid, pcId, instrId);
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    jumpReg = 1'b1;
    jrPc = 32'h500;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({pcId, imemAddr} !== {32'h314, 10'h0C6}) begin
        errors++;
        $display("[TB] FAIL enable_hold[%0d]: got pc=%h addr=%h want pc=314 addr=0c6", i, pcId, imemAddr);
      end
    end
    en = 1'b1;
    jumpReg = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] expPc;
      expPc = 32'h318 + 32'(4 * i);
      tick();
      checks++;
      if ({instrValid, pcId, instrId} !== {1'b1, expPc, wordAt(expPc)}) begin
        errors++;
        $display("[TB] FAIL enable_resume[%0d]: got pc=%h ins=%h want pc=%h", i, pcId, instrId, expPc);
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [2:0]  ctl [8] = '{3'b100, 3'b000, 3'b000, 3'b100, 0, 0, 0, 0};
    logic [31:0] jr  [8] = '{32'hFFFF_FFFC, 0, 0, 32'h0000_03FC, 0, 0, 0, 0};
    logic [31:0] ex  [8] = '{32'h320, 32'hFFFF_FFFC, 32'h0, 32'h4, 0, 0, 0, 0};
    run_steps("wrap", 4, ctl, jr, ex);
    stall = 1'b1;
    tick();
    checks++;
    if ({pcId, imemAddr} !== {32'h4, 10'h0FF}) begin
      errors++;
      $display("[TB] FAIL wrap_stall: got pc=%h addr=%h want pc=4 addr=0ff", pcId, imemAddr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({instrValid, instrId, pcId, imemAddr} !== {1'b0, 32'h0, 32'h0, 10'h040}) begin
      errors++;
      $display("[TB] FAIL midreset: got v=%b ins=%h pc=%h addr=%h want v=0 ins=0 pc=0 addr=040",
               instrValid, instrId, pcId, imemAddr);
    end
    tick();
    rst = 1'b0;
    stall = 1'b0;
    tick();
    checks++;
    if (instrValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_bubble: got v=%b want v=0", instrValid);
    end
    tick();
    checks++;
    if ({instrValid, pcId, instrId} !== {1'b1, 32'h100, wordAt(32'h100)}) begin
      errors++;
      $display("[TB] FAIL restart_pc: got v=%b pc=%h ins=%h want v=1 pc=100", instrValid, pcId, instrId);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[10'h080] = 32'h1000_0004;
    mem[10'h0C0] = 32'h1000_0004;
    mem[10'h010] = 32'h0800_0010;
    rst = 1'b1;
    en = 1'b1;
    stall = 1'b0;
    jumpBranch = 1'b0;
    jumpTarget = 1'b0;
    jumpReg = 1'b0;
    jrPc = 32'h0;
    test_reset();
    test_branch();
    test_jump();
    test_jr();
    test_stall();
    test_enable();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
